// File: rtl/ofifo_col_align_if.sv
// Bus bundle for the column-aligning output FIFO: per-column write side,
// row-wide read side and the status flags seen by the SFU.
interface ofifo_col_align_if #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int depth   = 64
);
   localparam int AW = $clog2(depth);

   logic [col-1:0]         wr;
   logic [psum_bw*col-1:0] in;
   logic                   rd;
   logic                   ofifo_valid;
   logic [psum_bw*col-1:0] ofifo_data;
   logic                   o_ready;
   logic                   o_full;
   logic                   o_overflow;
   logic [AW:0]            o_rows;

   // Producer/consumer side (MAC array + SFU, or a testbench).
   modport master (
      output wr, in, rd,
      input  ofifo_valid, ofifo_data, o_ready, o_full, o_overflow, o_rows
   );

   // The FIFO itself.
   modport slave (
      input  wr, in, rd,
      output ofifo_valid, ofifo_data, o_ready, o_full, o_overflow, o_rows
   );
endinterface

// File: rtl/ofifo_col_align.sv
// Output FIFO between the MAC-array columns and the SFU. Every column has its
// own first-word-fall-through FIFO so skewed psums line up again; a row is
// presented only when every column holds at least one entry, and all columns
// pop together.
module ofifo_col_align #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int depth   = 64
) (
   input logic                 clk,
   input logic                 reset,
   ofifo_col_align_if.slave    bus
);
   localparam int AW = $clog2(depth);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [col-1:0]              empty;
   logic [col-1:0]              full;
   logic [col-1:0]              wr_ok;
   logic [col-1:0]              drop;
   logic [col-1:0][AW:0]        fill;
   logic [col-1:0][psum_bw-1:0] head;
   logic                        valid;
   logic                        pop;
   logic                        overflow_reg;
   logic [AW:0]                 rows_min;

   // A row exists only when no column is empty; pops are all-or-nothing.
   assign valid = ~|empty;
   assign pop   = bus.rd && valid;

   generate
      for (genvar gi = 0; gi < col; gi++) begin : g_col
         logic [psum_bw-1:0] mem [depth];
         logic [AW:0]        wptr_reg;
         logic [AW:0]        rptr_reg;

         // Pointers carry one extra wrap bit so full and empty are distinct.
         assign empty[gi] = (wptr_reg == rptr_reg);
         assign full[gi]  = (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]) &&
                            (wptr_reg[AW] != rptr_reg[AW]);
         assign fill[gi]  = wptr_reg - rptr_reg;
         assign head[gi]  = mem[rptr_reg[AW-1:0]];

         // A write into a full column is kept only if the same edge frees a slot.
         assign wr_ok[gi] = bus.wr[gi] && (!full[gi] || pop);
         assign drop[gi]  = bus.wr[gi] && full[gi] && !pop;

         // Head is returned bit-exact; zeros whenever no full row is present.
         assign bus.ofifo_data[gi*psum_bw +: psum_bw] = valid ? head[gi] : '0;

         // Column pointer update: independent writes, shared row pop.
         always_ff @(posedge clk) begin
            if (reset) begin
               wptr_reg <= '0;
               rptr_reg <= '0;
            end else begin
               if (wr_ok[gi]) begin
                  wptr_reg <= wptr_reg + PTR_ONE;
               end
               if (pop) begin
                  rptr_reg <= rptr_reg + PTR_ONE;
               end
            end
         end

         // Column storage; the head is read asynchronously for fall-through.
         always_ff @(posedge clk) begin
            if (!reset && wr_ok[gi]) begin
               mem[wptr_reg[AW-1:0]] <= bus.in[gi*psum_bw +: psum_bw];
            end
         end
      end
   endgenerate

   // Rows available is limited by the least-filled column.
   always_comb begin
      rows_min = fill[0];
      for (int c = 1; c < col; c++) begin
         if (fill[c] < rows_min) begin
            rows_min = fill[c];
         end
      end
   end

   // Sticky overflow: set by any dropped column write, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_reg <= 1'b0;
      end else if (|drop) begin
         overflow_reg <= 1'b1;
      end
   end

   assign bus.ofifo_valid = valid;
   assign bus.o_full      = |full;
   assign bus.o_ready     = ~|full;
   assign bus.o_overflow  = overflow_reg;
   assign bus.o_rows      = rows_min;
endmodule

// File: tb/tb_ofifo_col_align.sv
// Self-checking bench for ofifo_col_align: a per-column queue scoreboard is
// fed on every accepted write and drained on every row pop; outputs are
// compared one step after each rising edge.
module tb_ofifo_col_align;
   localparam int COL = 8;
   localparam int BW  = 16;
   localparam int DEP = 64;

   logic clk;
   logic reset;

   ofifo_col_align_if #(.col(COL), .psum_bw(BW), .depth(DEP)) bus ();

   ofifo_col_align #(.col(COL), .psum_bw(BW), .depth(DEP)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int pop_cnt = 0;
   logic [BW-1:0] exp_q [COL][$];
   logic m_ovf = 1'b0;

   task automatic chk_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic model_valid();
      logic v = 1'b1;
      for (int c = 0; c < COL; c++) if (exp_q[c].size() == 0) v = 1'b0;
      return v;
   endfunction

   // Scoreboard update for the inputs present at this rising edge.
   task automatic model_update();
      logic m_pop;
      if (reset) begin
         for (int c = 0; c < COL; c++) exp_q[c].delete();
         m_ovf = 1'b0;
      end else begin
         m_pop = bus.rd && model_valid();
         for (int c = 0; c < COL; c++) begin
            if (bus.wr[c]) begin
               if (exp_q[c].size() >= DEP && !m_pop) m_ovf = 1'b1;
               else exp_q[c].push_back(bus.in[c*BW +: BW]);
            end
         end
         if (m_pop) begin
            for (int c = 0; c < COL; c++) void'(exp_q[c].pop_front());
         end
      end
   endtask

   task automatic check_outputs();
      logic          mv;
      int            rows;
      logic          mfull;
      logic [127:0]  mdata;
      mv = model_valid();
      rows = exp_q[0].size();
      mfull = 1'b0;
      mdata = '0;
      for (int c = 0; c < COL; c++) begin
         if (exp_q[c].size() < rows) rows = exp_q[c].size();
         if (exp_q[c].size() >= DEP) mfull = 1'b1;
         if (mv) mdata[c*BW +: BW] = exp_q[c][0];
      end
      chk_eq("valid", 128'(bus.ofifo_valid), 128'(mv));
      chk_eq("rows", 128'(bus.o_rows), 128'(rows));
      chk_eq("full", 128'(bus.o_full), 128'(mfull));
      chk_eq("ready", 128'(bus.o_ready), 128'(!mfull));
      chk_eq("overflow", 128'(bus.o_overflow), 128'(m_ovf));
      chk_eq("data", 128'(bus.ofifo_data), mdata);
   endtask

   // One clock: note a DUT pop, advance the model, then compare outputs.
   task automatic cycle();
      logic dut_pop;
      dut_pop = bus.rd && bus.ofifo_valid && !reset;
      @(posedge clk);
      model_update();
      if (dut_pop) pop_cnt++;
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.wr = '0;
      bus.rd = 1'b0;
      cycle();
      reset = 1'b0;
   endtask

   task automatic write_row(input logic [15:0] base);
      bus.wr = '1;
      for (int c = 0; c < COL; c++) bus.in[c*BW +: BW] = base + 16'(c);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int wcnt [COL];
      int budget;
      reset = 1'b1;
      bus.wr = '0;
      bus.in = '0;
      bus.rd = 1'b0;
      cycle();
      cycle();
      reset = 1'b0;
      chk_eq("rst_valid", 128'(bus.ofifo_valid), 128'(0));
      chk_eq("rst_ready", 128'(bus.o_ready), 128'(1));
      chk_eq("rst_data", 128'(bus.ofifo_data), 128'(0));
      chk_eq("rst_rows", 128'(bus.o_rows), 128'(0));

      // T1 skew
      for (int c = 0; c < COL; c++) begin
         bus.wr = '0;
         bus.wr[c] = 1'b1;
         bus.in = '0;
         bus.in[c*BW +: BW] = 16'h0100 + 16'(c);
         cycle();
         if (c < COL-1) chk_eq("t1_valid_low", 128'(bus.ofifo_valid), 128'(0));
      end
      bus.wr = '0;
      chk_eq("t1_valid", 128'(bus.ofifo_valid), 128'(1));
      chk_eq("t1_data", bus.ofifo_data, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
      bus.rd = 1'b1;
      cycle();
      bus.rd = 1'b0;
      chk_eq("t1_pop_valid", 128'(bus.ofifo_valid), 128'(0));
      chk_eq("t1_pop_rows", 128'(bus.o_rows), 128'(0));

      // T2 stream: 36 skewed rows, rd held high
      pop_cnt = 0;
      bus.rd = 1'b1;
      for (int t = 0; t < 36 + COL + 4; t++) begin
         bus.wr = '0;
         bus.in = '0;
         for (int c = 0; c < COL; c++) begin
            if (t - c >= 0 && t - c < 36) begin
               bus.wr[c] = 1'b1;
               bus.in[c*BW +: BW] = 16'((t - c) * 8 + c);
            end
         end
         cycle();
      end
      bus.wr = '0;
      bus.rd = 1'b0;
      chk_eq("t2_pops", 128'(pop_cnt), 128'(36));
      chk_eq("t2_ovf", 128'(bus.o_overflow), 128'(0));

      // T3 full / overflow
      do_reset();
      for (int r = 0; r < DEP; r++) begin
         write_row(16'h1000 + 16'(r * 8));
         cycle();
      end
      chk_eq("t3_full", 128'(bus.o_full), 128'(1));
      chk_eq("t3_ready", 128'(bus.o_ready), 128'(0));
      chk_eq("t3_rows", 128'(bus.o_rows), 128'(64));
      write_row(16'hDE00);
      cycle();
      bus.wr = '0;
      chk_eq("t3_ovf_set", 128'(bus.o_overflow), 128'(1));
      chk_eq("t3_ovf_rows", 128'(bus.o_rows), 128'(64));
      chk_eq("t3_head", bus.ofifo_data, 128'h1007_1006_1005_1004_1003_1002_1001_1000);
      pop_cnt = 0;
      bus.rd = 1'b1;
      for (int r = 0; r < DEP + 2; r++) cycle();
      bus.rd = 1'b0;
      chk_eq("t3_drain", 128'(pop_cnt), 128'(64));
      do_reset();
      for (int r = 0; r < DEP; r++) begin
         write_row(16'h2000 + 16'(r * 8));
         cycle();
      end
      write_row(16'h3000);
      bus.rd = 1'b1;
      cycle();
      bus.wr = '0;
      bus.rd = 1'b0;
      chk_eq("t3_wrpop_rows", 128'(bus.o_rows), 128'(64));
      chk_eq("t3_wrpop_ovf", 128'(bus.o_overflow), 128'(0));
      bus.rd = 1'b1;
      for (int r = 0; r < DEP + 1; r++) cycle();
      bus.rd = 1'b0;

      // T4 partial
      do_reset();
      for (int k = 0; k < 3; k++) begin
         write_row(16'h4000 + 16'(k * 8));
         bus.wr = 8'h7F;
         cycle();
      end
      write_row(16'h4100);
      bus.wr = 8'h80;
      cycle();
      bus.wr = '0;
      chk_eq("t4_rows", 128'(bus.o_rows), 128'(1));
      bus.rd = 1'b1;
      cycle();
      chk_eq("t4_valid", 128'(bus.ofifo_valid), 128'(0));
      cycle();
      bus.rd = 1'b0;
      chk_eq("t4_rows_after", 128'(bus.o_rows), 128'(0));

      // T5 wrap: 200 rows, random interleave, never full
      do_reset();
      pop_cnt = 0;
      budget = 0;
      for (int c = 0; c < COL; c++) wcnt[c] = 0;
      while (pop_cnt < 200 && budget < 6000) begin
         bus.wr = '0;
         for (int c = 0; c < COL; c++) begin
            if (wcnt[c] < 200 && exp_q[c].size() < 60 && $urandom_range(0, 1) == 1) begin
               bus.wr[c] = 1'b1;
               bus.in[c*BW +: BW] = 16'((c << 12) | wcnt[c]);
               wcnt[c]++;
            end
         end
         bus.rd = ($urandom_range(0, 1) == 1);
         cycle();
         budget++;
      end
      bus.wr = '0;
      bus.rd = 1'b0;
      chk_eq("t5_pops", 128'(pop_cnt), 128'(200));

      // T6 reset mid-operation
      for (int r = 0; r < 10; r++) begin
         write_row(16'h6000 + 16'(r * 8));
         cycle();
      end
      do_reset();
      chk_eq("t6_valid", 128'(bus.ofifo_valid), 128'(0));
      chk_eq("t6_rows", 128'(bus.o_rows), 128'(0));
      chk_eq("t6_ovf", 128'(bus.o_overflow), 128'(0));
      chk_eq("t6_data", 128'(bus.ofifo_data), 128'(0));
      write_row(16'hABC0);
      cycle();
      bus.wr = '0;
      chk_eq("t6_first", bus.ofifo_data, 128'hABC7_ABC6_ABC5_ABC4_ABC3_ABC2_ABC1_ABC0);
      bus.rd = 1'b1;
      cycle();
      bus.rd = 1'b0;
      chk_eq("t6_empty", 128'(bus.ofifo_valid), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
